// File: rtl/demux_dispatch.sv
// -----------------------------------------------------------------------------
// demux_dispatch
//
// Routes one request (lane select + payload) to exactly one of 2**N output
// lanes. It holds that lane until the lane acknowledges, or aborts after
// TIMEOUT drive cycles without an acknowledge. Only one request is in flight
// at a time. It sits between the vending controller and the per-slot
// dispenser/display lanes.
//
// Parameters:
//   N       - select width; the block has 2**N lanes
//   DATAW   - payload width per lane
//   TIMEOUT - maximum drive cycles without ack before abort (>= 1)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   request present
//   in_ready     out  block can accept a request (high in IDLE)
//   in_sel       in   destination lane index
//   in_data      in   payload
//   out_valid    out  one-hot lane valid
//   out_data     out  lane i occupies bits [i*DATAW +: DATAW]
//   out_ack      in   per-lane acknowledge
//   timeout_err  out  one-cycle pulse when a request is aborted
//   busy         out  high while a lane is being driven
// -----------------------------------------------------------------------------
module demux_dispatch #(
   parameter int N       = 2,
   parameter int DATAW   = 4,
   parameter int TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_sel,
   input  logic [DATAW-1:0]         in_data,
   output logic [(2**N)-1:0]        out_valid,
   output logic [(2**N)*DATAW-1:0]  out_data,
   input  logic [(2**N)-1:0]        out_ack,
   output logic                     timeout_err,
   output logic                     busy
);

   localparam int LANES = 2**N;
   localparam int CW    = $clog2(TIMEOUT + 1);

   // Counter value on the last permitted drive cycle.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t                   state_q,       state_d;
   logic [N-1:0]             sel_q,         sel_d;
   logic [CW-1:0]            cnt_q,         cnt_d;
   logic [LANES-1:0]         out_valid_q,   out_valid_d;
   logic [LANES*DATAW-1:0]   out_data_q,    out_data_d;
   logic                     timeout_err_q, timeout_err_d;

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      cnt_d         = cnt_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      timeout_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_DRIVE;
               sel_d   = in_sel;
               cnt_d   = '0;
               // Full decode: the payload lands only on the selected lane,
               // every other lane carries zeros.
               for (int i = 0; i < LANES; i++) begin
                  out_valid_d[i]                 = (in_sel == N'(i));
                  out_data_d[i*DATAW +: DATAW]   = (in_sel == N'(i)) ? in_data : '0;
               end
            end
         end

         ST_DRIVE: begin
            // Ack is checked first so an ack on the final cycle wins over
            // the timeout. Acks on other lanes are never looked at.
            if (out_ack[sel_q]) begin
               state_d     = ST_IDLE;
               out_valid_d = '0;
               out_data_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d       = ST_IDLE;
               out_valid_d   = '0;
               out_data_d    = '0;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d     = ST_IDLE;
            out_valid_d = '0;
            out_data_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sel_q         <= '0;
         cnt_q         <= '0;
         out_valid_q   <= '0;
         out_data_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         cnt_q         <= cnt_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // in_ready depends on state alone so a requester can hold its request
   // without creating a combinational loop through in_valid.
   assign in_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_DRIVE);
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign timeout_err = timeout_err_q;

endmodule
